bldac_ramp_ctrl: RTL
====================

Name: bldac_ramp_ctrl

Overview:
- Parametrised successor to the single-code bitline DAC front end.
- Holds an independent double-buffered code per channel:
  - a shadow register, written over a simple write port;
  - an active code, loaded on a global update strobe.
- Active codes either jump to the new value or slew-limit toward it (STEP codes every DIV clocks) to avoid bitline disturb.
- Drives N_CH real-valued analog outputs. Sits between the array sequencer and the bitline drivers.

Parameters:
- N_CH, 8, number of DAC channels (>=2)
- WIDTH, 8, code width per channel
- VREF, 3.3 (real), full-scale voltage at code 2**WIDTH-1
- STEP, 4, maximum code change per ramp tick (1..2**WIDTH-1)
- DIV, 16, clocks per ramp tick (>=2)
- CHW, $clog2(N_CH), channel index width (derived)

Ports:
- sys_clk, in, 1, system clock, rising edge
- sys_rst, in, 1, asynchronous active-high reset
- wr_en, in, 1, shadow write strobe
- wr_bcast, in, 1, when set with wr_en, write all channels (wr_ch ignored)
- wr_ch, in, CHW, target channel for wr_en
- wr_data, in, WIDTH, shadow code
- dac_update, in, 1, 1-cycle strobe: shadow -> target for all channels
- ramp_en, in, 1, 1 = slew-limited transition, 0 = immediate; sampled only with dac_update
- busy, out, 1, ramp in progress
- ramp_done, out, 1, 1-cycle pulse on ramp completion
- code_out, out, N_CH*WIDTH, active codes, channel i at [i*WIDTH +: WIDTH]
- analog_out, out, real [N_CH], VREF*code_i/(2**WIDTH-1)

Behaviour:
- Reset (async, immediate):
  - shadow, target and active codes = 0; prescaler = 0; state = IDLE.
  - busy = 0, ramp_done = 0, code_out = 0, analog_out = 0.0.
- Writes:
  - Accepted every cycle in any state.
  - shadow[wr_ch] <= wr_data on the clock edge. With wr_bcast, all shadows are written.
  - A write with wr_ch >= N_CH and wr_bcast = 0 is ignored.
- Simultaneous wr_en and dac_update: the update captures the pre-write shadow. The write lands in the shadow for the next update.
- FSM states: IDLE, RAMP.
- IDLE with dac_update:
  - target <= shadow for all channels.
  - If ramp_en = 0: active <= shadow on the same edge (code_out valid 1 cycle after the strobe). Stay in IDLE. No busy, no ramp_done.
  - If ramp_en = 1 and any shadow != active: go to RAMP, prescaler <= 0.
  - If ramp_en = 1 and all shadows equal their active codes: stay in IDLE, no pulse.
- RAMP:
  - Prescaler counts 0..DIV-1 and wraps. A tick occurs on the edge where prescaler == DIV-1.
  - On a tick, per channel: d = target - active, computed signed in WIDTH+1 bits.
  - If |d| <= STEP then active <= target, else active <= active ± STEP.
  - No wrap-around past 0 or 2**WIDTH-1.
- Exit: in the cycle after all active == target, go RAMP -> IDLE, prescaler <= 0, ramp_done = 1 for exactly one cycle.
- busy = (state == RAMP), registered.
- dac_update during RAMP (retarget):
  - target <= shadow; ramp continues from the current active codes toward the new targets.
  - Prescaler is not reset; ramp_en is ignored (the ramp is kept).
  - If the new targets already equal the active codes, normal exit applies.
- ramp_en changes outside a dac_update cycle have no effect.
- analog_out is a combinational function of the active code only.

Test Plan:
- Assert sys_rst mid-operation -> same cycle: code_out = 0, every analog_out = 0.0, busy = 0, ramp_done = 0.
- Write ch3 = 8'hFF, update with ramp_en = 0 -> 1 cycle later code[3] = 255, analog_out[3] = 3.3, other channels 0, busy never high.
- Defaults; write ch0 = 10, update (edge E0) with ramp_en = 1 -> busy = 1 after E0. code[0] = 4 after E16, 8 after E32, 10 after E48. ramp_done pulses for 1 cycle after E49, busy = 0 after E49.
- From ch0 = 255 (set by immediate update), write 250, update with ramp -> code[0] = 251 after the first tick, 250 after the second. No underflow.
- Broadcast write 8'h80, update with ramp_en = 0 -> all codes 128, analog ≈ 1.65647.
- Mid-ramp, write ch1 = 0 together with dac_update -> the old ch1 shadow is captured as target. A wr_ch = N_CH write is ignored. A second update retargets ch1 to 0 with no prescaler reset.

Source files
------------

// File: rtl/bldac_ramp_ctrl.sv
// Multi-channel double-buffered bitline DAC front end with optional slew limiting.
// Ports:
//   sys_clk, sys_rst   - clock (rising edge), asynchronous active-high reset
//   wr_en/wr_bcast     - shadow write strobe / write all channels
//   wr_ch, wr_data     - target channel and shadow code
//   dac_update         - shadow -> target strobe for all channels
//   ramp_en            - slew-limited (1) or immediate (0) transition, sampled with dac_update
//   busy, ramp_done    - ramp in progress / one-cycle completion pulse
//   code_out           - active codes, channel i at [i*WIDTH +: WIDTH]
//   analog_out         - VREF*code_i/(2**WIDTH-1) per channel
module bldac_ramp_ctrl #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned WIDTH = 8,
    parameter real         VREF  = 3.3,
    parameter int unsigned STEP  = 4,
    parameter int unsigned DIV   = 16,
    parameter int unsigned CHW   = $clog2(N_CH)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    wr_en,
    input  logic                    wr_bcast,
    input  logic [CHW-1:0]          wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    dac_update,
    input  logic                    ramp_en,
    output logic                    busy,
    output logic                    ramp_done,
    output logic [N_CH*WIDTH-1:0]   code_out,
    output real                     analog_out [N_CH]
);

    localparam int unsigned PW = $clog2(DIV);
    localparam real FULL_SCALE = real'((2 ** WIDTH) - 1);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shadow_q [N_CH];
    logic [WIDTH-1:0] shadow_d [N_CH];
    logic [WIDTH-1:0] target_q [N_CH];
    logic [WIDTH-1:0] target_d [N_CH];
    logic [WIDTH-1:0] active_q [N_CH];
    logic [WIDTH-1:0] active_d [N_CH];
    logic             all_eq;
    logic             any_diff;
    logic             tick;

    // One slew step: land on the target when within STEP, else move STEP toward it.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic signed [WIDTH:0] d;
        logic [WIDTH:0]        mag;
        d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag = $unsigned(d[WIDTH] ? -d : d);
        if (mag <= (WIDTH+1)'(STEP)) begin
            return tgt;
        end else if (d[WIDTH]) begin
            return cur - WIDTH'(STEP);
        end else begin
            return cur + WIDTH'(STEP);
        end
    endfunction

    // Ramp status comparisons.
    always_comb begin
        all_eq   = 1'b1;
        any_diff = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (active_q[i] != target_q[i]) all_eq = 1'b0;
            if (shadow_q[i] != active_q[i]) any_diff = 1'b1;
        end
    end

    assign tick = (presc_q == PW'(DIV - 1));

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        shadow_d = shadow_q;
        target_d = target_q;
        active_d = active_q;

        // Updates below read shadow_q, so a same-cycle write lands for the next update.
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en && (wr_bcast || (wr_ch == CHW'(i)))) shadow_d[i] = wr_data;
        end

        case (state_q)
            IDLE: begin
                if (dac_update) begin
                    target_d = shadow_q;
                    if (!ramp_en) begin
                        active_d = shadow_q;
                    end else if (any_diff) begin
                        state_d = RAMP;
                        presc_d = '0;
                    end
                end
            end
            RAMP: begin
                if (dac_update) target_d = shadow_q;
                // A retarget in the same cycle keeps the ramp alive.
                if (!dac_update && all_eq) begin
                    state_d = IDLE;
                    presc_d = '0;
                    done_d  = 1'b1;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        for (int i = 0; i < N_CH; i++) begin
                            active_d[i] = step_toward(active_q[i], target_q[i]);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RAMP);
    end

    // State and code registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= '0;
                target_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            target_q <= target_d;
            active_q <= active_d;
        end
    end

    assign busy      = busy_q;
    assign ramp_done = done_q;

    // Output packing and code-to-voltage conversion.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            code_out[i*WIDTH +: WIDTH] = active_q[i];
            analog_out[i]              = VREF * real'(active_q[i]) / FULL_SCALE;
        end
    end

endmodule
